// File: rtl/dot_product_accumulator_pkg.sv
// dot_product_accumulator_pkg
// Shared definitions for the dot-product accumulator and the multiplier it follows.
// The default geometry constants live here so that the multiplier instance and
// the tag delay line are built from the same latency value.
package dot_product_accumulator_pkg;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_LEN         = 8;
    localparam int DEF_MUL_LATENCY = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dot_product_accumulator_tag_delay.sv
// tag_delay
// DEPTH-stage shift register carrying the {valid, last} tag of each operand pair
// so that it emerges in the same cycle as the multiplier's product.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (clears all tags)
//   in_valid, in_last     tag entering the line
//   out_valid, out_last   tag leaving the line after DEPTH clock edges
module tag_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] lst_q, lst_d;

    // Next-state of the shift line: stage 0 takes the new tag, others shift up.
    always_comb begin
        vld_d    = vld_q;
        lst_d    = lst_q;
        vld_d[0] = in_valid;
        lst_d[0] = in_last;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            lst_d[i] = lst_q[i-1];
        end
    end

    // Tag line registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= vld_d;
            lst_q <= lst_d;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_last  = lst_q[DEPTH-1];

endmodule

// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
// Tags operand pairs issued to a fixed-latency pipelined multiplier, accumulates
// the matching products into a dot-product sum and returns one result per vector
// over a valid/ready handshake. Issue is throttled from the last element of a
// vector until the result has been taken, so only one vector is ever in flight.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid, in_last          operand pair issued / final element of the vector
//   in_ready                   upstream may issue (decoded from state)
//   prod                       multiplier product, MUL_LATENCY edges after issue
//   out_valid, out_ready       result handshake
//   out_sum                    dot-product sum modulo 2^ACC_WIDTH
//   out_count                  element count, saturating
//   len_err                    vector was longer than LEN
module dot_product_accumulator
    import dot_product_accumulator_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int LEN         = DEF_LEN,
    parameter int MUL_LATENCY = DEF_MUL_LATENCY,
    parameter int ACC_WIDTH   = 2*WIDTH + clog2(LEN),
    parameter int CNT_WIDTH   = clog2(LEN) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 len_err
);

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 first_q, first_d;
    logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
    logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                 len_err_q, len_err_d;
    logic                 out_valid_q, out_valid_d;
    logic                 accept_s;
    logic                 tag_valid_s;
    logic                 tag_last_s;

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_ACC);
    assign accept_s = in_valid && in_ready;

    tag_delay #(
        .DEPTH(MUL_LATENCY)
    ) u_tag_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept_s),
        .in_last   (in_last && accept_s),
        .out_valid (tag_valid_s),
        .out_last  (tag_last_s)
    );

    // Accumulator and counter update on tagged products; bubbles hold.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        if (tag_valid_s) begin
            if (first_q) begin
                acc_d = ACC_WIDTH'(prod);
                cnt_d = CNT_WIDTH'(1);
            end else begin
                acc_d = acc_q + ACC_WIDTH'(prod);
                if (cnt_q == {CNT_WIDTH{1'b1}}) begin
                    cnt_d = cnt_q;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            first_d = 1'b0;
        end else if ((state_q == ST_HOLD) && out_ready) begin
            // Next tagged product starts a fresh vector.
            first_d = 1'b1;
        end else begin
            first_d = first_q;
        end
    end

    // Control FSM and capture of the finished result.
    always_comb begin
        state_d     = state_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        len_err_d   = len_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = in_last ? ST_DRAIN : ST_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (accept_s && in_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DRAIN: begin
                if (tag_valid_s && tag_last_s) begin
                    state_d     = ST_HOLD;
                    out_sum_d   = acc_d;
                    out_count_d = cnt_d;
                    len_err_d   = (cnt_d > CNT_WIDTH'(LEN));
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        out_valid_d = (state_d == ST_HOLD);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            out_sum_q   <= '0;
            out_count_q <= '0;
            len_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            len_err_q   <= len_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign len_err   = len_err_q;

endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Downstream consumer of the pipelined array multiplier. It tags each operand pair issued to the multiplier and delays the tag to line up with the multiplier's fixed-latency product. It then accumulates the tagged products into a dot-product sum and delivers one result per vector over a valid/ready handshake. Because the multiplier cannot stall, upstream issue is throttled through `in_ready`.

## Interface
- `WIDTH`, 4: multiplier operand width; product is 2*WIDTH bits.
- `LEN`, 8: nominal vector length.
- `MUL_LATENCY`, 3: clock edges from operands at multiplier input to the product valid on its output.
- `ACC_WIDTH`, 11: accumulator width, 2*WIDTH + clog2(LEN).
- `CNT_WIDTH`, 4: element counter width, clog2(LEN)+1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair presented to the multiplier this cycle.
- `in_last`  in  1  pair is the final element of the vector; qualified by `in_valid`.
- `in_ready`  out  1  upstream may issue; transfer occurs when `in_valid && in_ready`.
- `prod`  in  2*WIDTH  multiplier product output.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts result.
- `out_sum`  out  ACC_WIDTH  dot-product sum, modulo 2^ACC_WIDTH.
- `out_count`  out  CNT_WIDTH  elements in the vector, saturating at 2^CNT_WIDTH-1.
- `len_err`  out  1  vector had more than LEN elements; valid with `out_valid`.

## Operation
- The accepted `{valid, last}` tag enters a MUL_LATENCY-deep shift register. Its output qualifies `prod` in the same cycle.
- Tagged product with the first-element flag set: the accumulator loads `prod`, zero-extended to ACC_WIDTH, and the counter loads 1. Otherwise the accumulator adds `prod` and the counter increments, saturating.
- Untagged cycles (bubbles) leave the accumulator and counter unchanged.
- FSM:
  - IDLE: `in_ready`=1. An accepted element goes to ACC, or to DRAIN if it carries `in_last`.
  - ACC: `in_ready`=1. An accepted element with `in_last` goes to DRAIN.
  - DRAIN: `in_ready`=0. When the tagged-last product is accumulated, the sum, count and `len_err` are registered and the FSM goes to HOLD.
  - HOLD: `out_valid`=1 and outputs are stable. On `out_valid && out_ready` the FSM goes to IDLE and `out_valid` drops the next cycle.
- `len_err` = (final count > LEN).
- The first-element flag is set at reset and on leaving HOLD. It is cleared when the first tagged product is accumulated.

## Timing
- Reset: state IDLE, all tags 0, accumulator 0, `out_sum`=0, `out_count`=0, `len_err`=0, `out_valid`=0, `in_ready`=1 (combinational from state).
- Throughput: one element per cycle in IDLE/ACC.
- Latency: `in_last` accepted in cycle t gives `out_valid`=1 in cycle t+MUL_LATENCY+1 (t+4 at default).
- No new vector is accepted from the `in_last` cycle until the cycle after the output handshake. As a result, no foreign product is ever in flight.
- Same-cycle `out_valid && out_ready` in HOLD: `in_ready`=1 in the next cycle. `out_ready` asserted early (before HOLD) is ignored.
- Reset asserted mid-vector or in DRAIN: in-flight tags and partial sum are discarded and no `out_valid` is produced.
- Sum overflow wraps silently; `len_err` is the only indicator.

## Structure
- Shared package holds:
  - FSM state enum (IDLE, ACC, DRAIN, HOLD).
  - clog2 function.
  - Default WIDTH/LEN/MUL_LATENCY constants, shared with the multiplier instance so the latencies stay in lockstep.
- One sub-module, `tag_delay`: parameterised-depth shift register for `{valid, last}` with async active-low reset to 0.

## Test plan
- Vector (3,5),(2,7),(15,15) with last on the third, `out_ready`=1 → `out_sum`=254, `out_count`=3, `len_err`=0, `out_valid` 4 cycles after last accepted, for one cycle.
- Single element (0,9) with `in_last` → `out_sum`=0, `out_count`=1. Then (1,1) alone → `out_sum`=1, confirming no carry-over.
- Back-pressure: complete (2,2),(3,3), hold `out_ready`=0 for 5 cycles → `out_sum`=13 stable, `in_ready`=0 throughout. Handshake → `in_ready`=1 next cycle.
- Bubbles: (4,4), 3 idle cycles, (5,5) last → `out_sum`=41, `out_count`=2.
- Overlength: 9× (15,15) → `out_sum`=2025, `out_count`=9, `len_err`=1. 16× (15,15) → `out_count`=15 (saturated), `out_sum`=3600 mod 2048=1552.
- Reset during DRAIN → no `out_valid`. After release, `in_ready`=1 and vector (6,6) last → `out_sum`=36.
